// File: rtl/add_rs_dispatch.sv
// add_rs_dispatch: adder reservation station with oldest-ready select and
// dispatch into the add/sub execution unit.
//
// Optional feature macro: ADD_RS_CDB_FWD_EN
//   defined   - select also sees sources being woken by the CDB this cycle and
//               forwards cdb_data straight to the dispatched operand (1-cycle
//               wakeup-to-ex_b).
//   undefined - woken operands are written to the entry first and become
//               eligible the following cycle (2-cycle wakeup-to-ex_b).
//
// Ports:
//   clk1, rst                 clock, synchronous active-high reset
//   issue_*                   issue handshake and op payload (issue_ready out)
//   cdb_valid/cdb_tag/cdb_data common data bus snoop
//   exec_done                 exec unit finished pulse (unit is now free)
//   ex_b, rs_index, rs1_data, rs2_data, func, rob_ind, rd
//                             registered dispatch interface to exec unit
//   occupancy                 number of valid entries
module add_rs_dispatch #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned RW    = 4,
  parameter int unsigned ROBW  = 3
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [3:0]      issue_func,
  input  logic [RW-1:0]   issue_rd,
  input  logic [ROBW-1:0] issue_rob,
  input  logic            issue_src1_rdy,
  input  logic            issue_src2_rdy,
  input  logic [RW-1:0]   issue_src1_tag,
  input  logic [RW-1:0]   issue_src2_tag,
  input  logic [DW-1:0]   issue_src1_val,
  input  logic [DW-1:0]   issue_src2_val,
  input  logic            cdb_valid,
  input  logic [RW-1:0]   cdb_tag,
  input  logic [DW-1:0]   cdb_data,
  input  logic            exec_done,
  output logic            ex_b,
  output logic [2:0]      rs_index,
  output logic [DW-1:0]   rs1_data,
  output logic [DW-1:0]   rs2_data,
  output logic [3:0]      func,
  output logic [ROBW-1:0] rob_ind,
  output logic [RW-1:0]   rd,
  output logic [2:0]      occupancy
);

  localparam int unsigned SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AW = 2;
  localparam int unsigned IW = 3;
  localparam int unsigned OW = 3;

  // Entry storage
  logic            r_valid   [DEPTH];
  logic [3:0]      r_func    [DEPTH];
  logic [RW-1:0]   r_rd      [DEPTH];
  logic [ROBW-1:0] r_rob     [DEPTH];
  logic [AW-1:0]   r_age     [DEPTH];
  logic            r_s1_rdy  [DEPTH];
  logic            r_s2_rdy  [DEPTH];
  logic [RW-1:0]   r_s1_tag  [DEPTH];
  logic [RW-1:0]   r_s2_tag  [DEPTH];
  logic [DW-1:0]   r_s1_val  [DEPTH];
  logic [DW-1:0]   r_s2_val  [DEPTH];
  logic            r_exec_busy;

  // Effective per-entry operand readiness/value as seen by select
  logic            w_s1_rdy  [DEPTH];
  logic            w_s2_rdy  [DEPTH];
  logic [DW-1:0]   w_s1_val  [DEPTH];
  logic [DW-1:0]   w_s2_val  [DEPTH];

  logic            w_sel_found;
  logic [SW-1:0]   w_sel_idx;
  logic [AW-1:0]   w_sel_age;
  logic            w_disp;
  logic            w_free_found;
  logic [SW-1:0]   w_free_idx;
  logic            w_issue;
  logic            w_iss_s1_hit;
  logic            w_iss_s2_hit;

  assign issue_ready  = (occupancy < OW'(DEPTH)) && !rst;
  assign w_issue      = issue_valid && issue_ready;
  assign w_iss_s1_hit = !issue_src1_rdy && cdb_valid && (issue_src1_tag == cdb_tag);
  assign w_iss_s2_hit = !issue_src2_rdy && cdb_valid && (issue_src2_tag == cdb_tag);

  // Operand view used by select; with forwarding a same-cycle CDB hit counts
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef ADD_RS_CDB_FWD_EN
      w_s1_rdy[i] = r_s1_rdy[i] || (cdb_valid && (r_s1_tag[i] == cdb_tag));
      w_s2_rdy[i] = r_s2_rdy[i] || (cdb_valid && (r_s2_tag[i] == cdb_tag));
      w_s1_val[i] = r_s1_rdy[i] ? r_s1_val[i] : cdb_data;
      w_s2_val[i] = r_s2_rdy[i] ? r_s2_val[i] : cdb_data;
`else
      w_s1_rdy[i] = r_s1_rdy[i];
      w_s2_rdy[i] = r_s2_rdy[i];
      w_s1_val[i] = r_s1_val[i];
      w_s2_val[i] = r_s2_val[i];
`endif
    end
  end

  // Oldest ready entry; strict '>' keeps the lowest index on an age tie
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && w_s1_rdy[i] && w_s2_rdy[i] &&
          (!w_sel_found || (r_age[i] > w_sel_age))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = SW'(i);
        w_sel_age   = r_age[i];
      end
    end
  end

  assign w_disp = w_sel_found && (!r_exec_busy || exec_done);

  // Lowest-index free slot from registered state only
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = SW'(i);
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_func[i]   <= '0;
        r_rd[i]     <= '0;
        r_rob[i]    <= '0;
        r_age[i]    <= '0;
        r_s1_rdy[i] <= 1'b0;
        r_s2_rdy[i] <= 1'b0;
        r_s1_tag[i] <= '0;
        r_s2_tag[i] <= '0;
        r_s1_val[i] <= '0;
        r_s2_val[i] <= '0;
      end
      r_exec_busy <= 1'b0;
      ex_b        <= 1'b0;
      rs_index    <= '0;
      rs1_data    <= '0;
      rs2_data    <= '0;
      func        <= '0;
      rob_ind     <= '0;
      rd          <= '0;
      occupancy   <= '0;
    end else begin
      ex_b <= 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
        // CDB wakeup of waiting sources
        if (r_valid[i] && !r_s1_rdy[i] && cdb_valid && (r_s1_tag[i] == cdb_tag)) begin
          r_s1_rdy[i] <= 1'b1;
          r_s1_val[i] <= cdb_data;
        end
        if (r_valid[i] && !r_s2_rdy[i] && cdb_valid && (r_s2_tag[i] == cdb_tag)) begin
          r_s2_rdy[i] <= 1'b1;
          r_s2_val[i] <= cdb_data;
        end
        // Existing entries age on every accepted issue, saturating
        if (w_issue && r_valid[i] && (r_age[i] < AW'(DEPTH - 1)))
          r_age[i] <= r_age[i] + AW'(1);
      end

      // Free slot is invalid in registered state, so it never collides with
      // the wakeup/aging updates above or the dispatched entry below
      if (w_issue) begin
        r_valid[w_free_idx]  <= 1'b1;
        r_func[w_free_idx]   <= issue_func;
        r_rd[w_free_idx]     <= issue_rd;
        r_rob[w_free_idx]    <= issue_rob;
        r_age[w_free_idx]    <= '0;
        r_s1_tag[w_free_idx] <= issue_src1_tag;
        r_s2_tag[w_free_idx] <= issue_src2_tag;
        r_s1_rdy[w_free_idx] <= issue_src1_rdy || w_iss_s1_hit;
        r_s2_rdy[w_free_idx] <= issue_src2_rdy || w_iss_s2_hit;
        r_s1_val[w_free_idx] <= issue_src1_rdy ? issue_src1_val : cdb_data;
        r_s2_val[w_free_idx] <= issue_src2_rdy ? issue_src2_val : cdb_data;
      end

      if (w_disp) begin
        r_valid[w_sel_idx] <= 1'b0;
        ex_b               <= 1'b1;
        rs_index           <= IW'(w_sel_idx);
        rs1_data           <= w_s1_val[w_sel_idx];
        rs2_data           <= w_s2_val[w_sel_idx];
        func               <= r_func[w_sel_idx];
        rob_ind            <= r_rob[w_sel_idx];
        rd                 <= r_rd[w_sel_idx];
      end

      // Dispatch wins over a same-cycle exec_done
      if (w_disp)
        r_exec_busy <= 1'b1;
      else if (exec_done)
        r_exec_busy <= 1'b0;

      case ({w_issue, w_disp})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_add_rs_dispatch.sv
// Directed testbench for add_rs_dispatch.
module tb_add_rs_dispatch;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_func;
  logic [3:0] issue_rd;
  logic [2:0] issue_rob;
  logic       issue_src1_rdy, issue_src2_rdy;
  logic [3:0] issue_src1_tag, issue_src2_tag;
  logic [7:0] issue_src1_val, issue_src2_val;
  logic       cdb_valid;
  logic [3:0] cdb_tag;
  logic [7:0] cdb_data;
  logic       exec_done;
  logic       ex_b;
  logic [2:0] rs_index;
  logic [7:0] rs1_data, rs2_data;
  logic [3:0] func;
  logic [2:0] rob_ind;
  logic [3:0] rd;
  logic [2:0] occupancy;

  int n_pass  = 0;
  int n_total = 0;

  // {ex_b, rs_index, rs1, rs2, func, rob, rd, occupancy, issue_ready}
  logic [34:0] obs_full;
  logic [4:0]  obs_st;
  logic [34:0] exp_full;
  logic [4:0]  exp_st;
  assign obs_full = {ex_b, rs_index, rs1_data, rs2_data, func, rob_ind, rd, occupancy, issue_ready};
  assign obs_st   = {ex_b, occupancy, issue_ready};

  add_rs_dispatch dut (
    .clk1(clk1), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_func(issue_func), .issue_rd(issue_rd), .issue_rob(issue_rob),
    .issue_src1_rdy(issue_src1_rdy), .issue_src2_rdy(issue_src2_rdy),
    .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
    .issue_src1_val(issue_src1_val), .issue_src2_val(issue_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .exec_done(exec_done),
    .ex_b(ex_b), .rs_index(rs_index), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .func(func), .rob_ind(rob_ind), .rd(rd), .occupancy(occupancy)
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic clr_in();
    issue_valid = 0; issue_func = 0; issue_rd = 0; issue_rob = 0;
    issue_src1_rdy = 0; issue_src2_rdy = 0; issue_src1_tag = 0; issue_src2_tag = 0;
    issue_src1_val = 0; issue_src2_val = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; exec_done = 0;
  endtask

  task automatic drive_issue(input logic [3:0] f, input logic [3:0] d, input logic [2:0] rob,
                             input logic r1, input logic [3:0] t1, input logic [7:0] v1,
                             input logic r2, input logic [3:0] t2, input logic [7:0] v2);
    issue_valid = 1; issue_func = f; issue_rd = d; issue_rob = rob;
    issue_src1_rdy = r1; issue_src1_tag = t1; issue_src1_val = v1;
    issue_src2_rdy = r2; issue_src2_tag = t2; issue_src2_val = v2;
  endtask

  task automatic pulse_exec_done();
    exec_done = 1;
    tick();
    exec_done = 0;
  endtask

  task automatic test_reset();
    rst = 1; clr_in();
    tick(); tick();
    exp_full = 35'd0;
    if (obs_full !== exp_full) begin $display("FAIL reset_hold got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
    rst = 0; #1;
    exp_full = {1'b0, 3'd0, 8'd0, 8'd0, 4'd0, 3'd0, 4'd0, 3'd0, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL reset_release got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
  endtask

  task automatic test_basic_add();
    drive_issue(4'b0000, 4'd3, 3'd1, 1, 4'd0, 8'd5, 1, 4'd0, 8'd7);
    tick(); clr_in();
    exp_st = {1'b0, 3'd1, 1'b1};
    if (obs_st !== exp_st) begin $display("FAIL add_issued got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    tick();
    exp_full = {1'b1, 3'd0, 8'd5, 8'd7, 4'b0000, 3'd1, 4'd3, 3'd0, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL add_dispatch got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
    pulse_exec_done();
    exp_full = {1'b0, 3'd0, 8'd5, 8'd7, 4'b0000, 3'd1, 4'd3, 3'd0, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL add_strobe_hold got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
  endtask

  task automatic test_full_and_wakeup();
    drive_issue(4'b0000, 4'd1, 3'd0, 0, 4'd2, 8'd0, 1, 4'd0, 8'd1); tick();
    drive_issue(4'b0000, 4'd4, 3'd1, 0, 4'd2, 8'd0, 1, 4'd0, 8'd2); tick();
    drive_issue(4'b0000, 4'd5, 3'd2, 0, 4'd2, 8'd0, 1, 4'd0, 8'd3); tick();
    exp_st = {1'b0, 3'd3, 1'b0};
    if (obs_st !== exp_st) begin $display("FAIL full got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    // Fourth issue while full must be dropped
    drive_issue(4'b0001, 4'd15, 3'd7, 1, 4'd0, 8'hAA, 1, 4'd0, 8'hBB); tick(); clr_in();
    exp_st = {1'b0, 3'd3, 1'b0};
    if (obs_st !== exp_st) begin $display("FAIL full_ignore got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    // Non-matching broadcast wakes nothing
    cdb_valid = 1; cdb_tag = 4'd3; cdb_data = 8'hEE; tick(); clr_in(); tick();
    exp_st = {1'b0, 3'd3, 1'b0};
    if (obs_st !== exp_st) begin $display("FAIL cdb_nomatch got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    cdb_valid = 1; cdb_tag = 4'd2; cdb_data = 8'd9; tick(); clr_in();
`ifndef ADD_RS_CDB_FWD_EN
    exp_st = {1'b0, 3'd3, 1'b0};
    if (obs_st !== exp_st) begin $display("FAIL wake_latency got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    tick();
`endif
    exp_full = {1'b1, 3'd0, 8'd9, 8'd1, 4'b0000, 3'd0, 4'd1, 3'd2, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL wake_dispatch got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
  endtask

  task automatic test_exec_busy();
    tick(); tick();
    exp_st = {1'b0, 3'd2, 1'b1};
    if (obs_st !== exp_st) begin $display("FAIL busy_stall got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    pulse_exec_done();
    exp_full = {1'b1, 3'd1, 8'd9, 8'd2, 4'b0000, 3'd1, 4'd4, 3'd1, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL busy_disp1 got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
    // Dispatch in the exec_done cycle kept exec busy
    tick(); tick();
    exp_st = {1'b0, 3'd1, 1'b1};
    if (obs_st !== exp_st) begin $display("FAIL busy_kept got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    pulse_exec_done();
    exp_full = {1'b1, 3'd2, 8'd9, 8'd3, 4'b0000, 3'd2, 4'd5, 3'd0, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL busy_disp2 got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
    pulse_exec_done();
    exp_st = {1'b0, 3'd0, 1'b1};
    if (obs_st !== exp_st) begin $display("FAIL busy_drain got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
  endtask

  task automatic test_issue_cdb_capture();
    drive_issue(4'b0000, 4'd6, 3'd3, 1, 4'd0, 8'h10, 0, 4'd4, 8'h00);
    cdb_valid = 1; cdb_tag = 4'd4; cdb_data = 8'h21;
    tick(); clr_in();
    exp_st = {1'b0, 3'd1, 1'b1};
    if (obs_st !== exp_st) begin $display("FAIL cap_issued got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    tick();
    exp_full = {1'b1, 3'd0, 8'h10, 8'h21, 4'b0000, 3'd3, 4'd6, 3'd0, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL cap_dispatch got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
    pulse_exec_done();
  endtask

  task automatic test_sub();
    drive_issue(4'b0001, 4'd7, 3'd4, 1, 4'd0, 8'd3, 1, 4'd0, 8'd5);
    tick(); clr_in(); tick();
    exp_full = {1'b1, 3'd0, 8'd3, 8'd5, 4'b0001, 3'd4, 4'd7, 3'd0, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL sub_dispatch got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
    pulse_exec_done();
  endtask

  task automatic test_mid_reset();
    drive_issue(4'b0000, 4'd2, 3'd5, 1, 4'd0, 8'd1, 1, 4'd0, 8'd1); tick();
    // Issue and dispatch in the same cycle: occupancy unchanged
    drive_issue(4'b0000, 4'd8, 3'd6, 1, 4'd0, 8'd4, 1, 4'd0, 8'd4); tick();
    exp_full = {1'b1, 3'd0, 8'd1, 8'd1, 4'b0000, 3'd5, 4'd2, 3'd1, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL mr_simul got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
    drive_issue(4'b0000, 4'd9, 3'd7, 1, 4'd0, 8'd6, 1, 4'd0, 8'd6); tick(); clr_in(); tick();
    exp_st = {1'b0, 3'd2, 1'b1};
    if (obs_st !== exp_st) begin $display("FAIL mr_busy got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    rst = 1; tick();
    exp_full = 35'd0;
    if (obs_full !== exp_full) begin $display("FAIL mr_reset got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
    rst = 0; #1;
    exp_st = {1'b0, 3'd0, 1'b1};
    if (obs_st !== exp_st) begin $display("FAIL mr_release got=%b exp=%b", obs_st, exp_st); end else n_pass++;
    n_total++;
    drive_issue(4'b0000, 4'd1, 3'd2, 1, 4'd0, 8'h11, 1, 4'd0, 8'h22);
    tick(); clr_in(); tick();
    exp_full = {1'b1, 3'd0, 8'h11, 8'h22, 4'b0000, 3'd2, 4'd1, 3'd0, 1'b1};
    if (obs_full !== exp_full) begin $display("FAIL mr_fresh got=%h exp=%h", obs_full, exp_full); end else n_pass++;
    n_total++;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_full_and_wakeup();
    test_exec_busy();
    test_issue_cdb_capture();
    test_sub();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
